nxn_game_engine: RTL and testbench
==================================

# nxn_game_engine

Parametrised N×N, K-in-a-row game engine for two sides: the player and the computer. It generalises the fixed 3×3 tic-tac-toe core in three ways: configurable board size and win length, edge-detected move strobes, and a fixed-latency sequential win checker that reports draws. It sits between the move-entry logic (player pad, computer move generator) and the board display/score logic.

## Interface
Parameters:
- N, 3: board side; legal range 3..8.
- K, 3: marks in a row needed to win; legal range 3..N.
- POS_W, $clog2(N*N): position index width (derived; do not override).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low (asserted when 0).
- clr  in  1  synchronous new-game clear; overrides move strobes.
- pp  in  1  player move strobe (level).
- pc  in  1  computer move strobe (level).
- player_position  in  POS_W  player cell index, row-major, 0-based (row*N+col).
- computer_position  in  POS_W  computer cell index.
- board  out  2*N*N  cell i at bits [2i+1:2i]; 00 empty, 01 player, 10 computer.
- who  out  2  00 in play, 01 player won, 10 computer won, 11 draw.
- turn  out  1  0 player to move, 1 computer to move.
- busy  out  1  high while the win check runs.
- illegal  out  1  one-cycle pulse for a rejected move.
- move_cnt  out  $clog2(N*N+1)  number of marks placed.

## Operation
- States: P_TURN, C_TURN, CHK (4 sub-cycles, dir 0..3), DONE.
- Reset (rst=0): board all 00, who=00, turn=0, busy=0, illegal=0, move_cnt=0, state P_TURN, strobe history registers cleared.
- Strobe edge: pp_q/pc_q register the previous pp/pc. A request is pp&&!pp_q (or pc&&!pc_q). A held strobe produces exactly one request.
- Accept a request when its side owns the turn (P_TURN for pp, C_TURN for pc), position < N*N, and the cell is 00. On accept: write the mark (01 or 10), increment move_cnt, latch last position and mark, go to CHK.
- Reject any request that is off-turn, out of range, targets an occupied cell, or arrives in CHK or DONE. On reject: illegal=1 for one cycle; no other state changes.
- pp and pc edges in the same cycle: the on-turn one is evaluated normally; the off-turn one is rejected. illegal pulses once if either is rejected.
- CHK dir d ∈ {(0,+1), (+1,0), (+1,+1), (+1,−1)}. Run length = 1 + consecutive cells equal to the mark going forward (max K−1 cells, stop at board edge) + same count going backward. A run length ≥ K sets a sticky win flag.
- After dir 3:
  - win flag set: who = mark, state DONE.
  - else move_cnt == N*N: who = 11, state DONE.
  - else toggle turn and go to the other side's TURN state.
- DONE holds board and who until clr or rst.
- clr=1: same effect as reset, applied synchronously. It wins over any simultaneous request and does not pulse illegal.

## Timing
- Request sampled at edge T: the board cell and move_cnt are visible after T. busy=1 during cycles T+1..T+4. who, turn, and state update at edge T+4 and are visible from T+5.
- The next request is accepted from edge T+5. A strobe edge that falls in T+1..T+4 is rejected, not queued.
- illegal is asserted in the cycle after the rejecting edge, for exactly one cycle.
- rst asserted at any point, including mid-CHK, clears all outputs immediately, without waiting for clk.

## Test plan
- N=3,K=3; moves P4, C0, P8, C1, P6, C2 (each pp/pc held 5 cycles) → after the last check, who=10, board cells 0,1,2=10, cells 4,6,8=01, move_cnt=6.
- N=3,K=3; P0, C4, P1, C8, P2 → who=01 at T+5 of the 5th move; a further pc edge → illegal pulse, board unchanged.
- N=3,K=3; P0, C1, P2, C4, P3, C5, P7, C6, P8 → who=11, move_cnt=9.
- Rejects: P4 then C4 (occupied), then C9 (out of range), then pp during C_TURN, then a pc edge during busy → each gives exactly one illegal pulse; board and turn unchanged.
- N=5,K=4; player anti-diagonal at cells 3, 7, 11, 15 with computer moves in between → who=01. A 3-long run alone leaves who=00.
- rst low during busy → board=0, who=00, turn=0 immediately. clr coincident with a pp edge → board cleared and illegal=0.

Source files
------------

// File: rtl/nxn_game_engine.sv
// nxn_game_engine: N x N board, K-in-a-row game engine for player vs computer.
// Move strobes are edge-detected, each accepted move is followed by a
// four-cycle win check (one direction per cycle), and draws are reported.
//
// Strobe protocol: pp/pc are level inputs. A request is a rising edge of the
// strobe, so a held strobe produces exactly one request. A request is taken
// only in the cycle its edge is seen; it is accepted or rejected on that edge
// and is never queued. A rejection produces a one-cycle illegal pulse.
module nxn_game_engine #(
  parameter int N     = 3,
  parameter int K     = 3,
  parameter int POS_W = $clog2(N*N)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       pp,
  input  logic                       pc,
  input  logic [POS_W-1:0]           player_position,
  input  logic [POS_W-1:0]           computer_position,
  output logic [2*N*N-1:0]           board,
  output logic [1:0]                 who,
  output logic                       turn,
  output logic                       busy,
  output logic                       illegal,
  output logic [$clog2(N*N+1)-1:0]   move_cnt,
  output logic [1:0]                 dbg_state
);

  localparam int CELLS = N*N;
  localparam int CNT_W = $clog2(N*N+1);
  localparam logic [POS_W:0] CELLS_P = (POS_W+1)'(CELLS);
  localparam logic [CNT_W-1:0] CELLS_C = CNT_W'(CELLS);

  typedef enum logic [1:0] {P_TURN, C_TURN, CHK, DONE} state_e;

  state_e              state_q;
  logic [1:0]          dir_q;
  logic [2*N*N-1:0]    board_q;
  logic [2*N*N-1:0]    board_d;
  logic [1:0]          who_q;
  logic                turn_q;
  logic                busy_q;
  logic                illegal_q;
  logic [CNT_W-1:0]    move_cnt_q;
  logic                pp_q;
  logic                pc_q;
  logic [POS_W-1:0]    last_pos_q;
  logic [1:0]          last_mark_q;
  logic                win_q;
  logic                win_d;

  logic                p_req;
  logic                c_req;
  logic                p_ok;
  logic                c_ok;
  logic                acc;
  logic                rej;
  logic [POS_W-1:0]    acc_pos;
  logic [1:0]          acc_mark;
  int                  run_len;
  logic                run_hit;

  // Cell read that treats out-of-range indices as occupied.
  function automatic logic [1:0] cell_at(input logic [2*N*N-1:0] b, input int idx);
    if (idx >= 0 && idx < CELLS) return b[2*idx +: 2];
    return 2'b11;
  endfunction

  assign p_req = pp && !pp_q;
  assign c_req = pc && !pc_q;

  // Acceptance needs the owning turn state, an in-range position and an empty cell.
  always_comb begin
    p_ok = (state_q == P_TURN) && ({1'b0, player_position} < CELLS_P) &&
           (cell_at(board_q, int'(player_position)) == 2'b00);
    c_ok = (state_q == C_TURN) && ({1'b0, computer_position} < CELLS_P) &&
           (cell_at(board_q, int'(computer_position)) == 2'b00);
    acc      = (p_req && p_ok) || (c_req && c_ok);
    rej      = (p_req && !p_ok) || (c_req && !c_ok);
    acc_pos  = (p_req && p_ok) ? player_position : computer_position;
    acc_mark = (p_req && p_ok) ? 2'b01 : 2'b10;
    board_d  = board_q;
    if (acc) board_d[2*int'(acc_pos) +: 2] = acc_mark;
  end

  // Run length through the last move along the direction selected by dir_q.
  always_comb begin
    int r, c, dr, dc, rr, cc;
    logic fwd_ok, bwd_ok;
    r = int'(last_pos_q) / N;
    c = int'(last_pos_q) % N;
    case (dir_q)
      2'd0:    begin dr = 0; dc = 1;  end
      2'd1:    begin dr = 1; dc = 0;  end
      2'd2:    begin dr = 1; dc = 1;  end
      default: begin dr = 1; dc = -1; end
    endcase
    run_len = 1;
    fwd_ok  = 1'b1;
    bwd_ok  = 1'b1;
    rr      = 0;
    cc      = 0;
    for (int s = 1; s < K; s++) begin
      rr = r + s*dr;
      cc = c + s*dc;
      if (fwd_ok && rr >= 0 && rr < N && cc >= 0 && cc < N &&
          cell_at(board_q, rr*N + cc) == last_mark_q)
        run_len = run_len + 1;
      else
        fwd_ok = 1'b0;
      rr = r - s*dr;
      cc = c - s*dc;
      if (bwd_ok && rr >= 0 && rr < N && cc >= 0 && cc < N &&
          cell_at(board_q, rr*N + cc) == last_mark_q)
        run_len = run_len + 1;
      else
        bwd_ok = 1'b0;
    end
    run_hit = (run_len >= K);
    win_d   = win_q || run_hit;
  end

  // Game FSM: move acceptance, four-direction check, end-of-game resolution.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= P_TURN;
      dir_q       <= 2'd0;
      board_q     <= '0;
      who_q       <= 2'b00;
      turn_q      <= 1'b0;
      busy_q      <= 1'b0;
      illegal_q   <= 1'b0;
      move_cnt_q  <= '0;
      pp_q        <= 1'b0;
      pc_q        <= 1'b0;
      last_pos_q  <= '0;
      last_mark_q <= 2'b00;
      win_q       <= 1'b0;
    end else if (clr) begin
      state_q     <= P_TURN;
      dir_q       <= 2'd0;
      board_q     <= '0;
      who_q       <= 2'b00;
      turn_q      <= 1'b0;
      busy_q      <= 1'b0;
      illegal_q   <= 1'b0;
      move_cnt_q  <= '0;
      pp_q        <= 1'b0;
      pc_q        <= 1'b0;
      last_pos_q  <= '0;
      last_mark_q <= 2'b00;
      win_q       <= 1'b0;
    end else begin
      pp_q      <= pp;
      pc_q      <= pc;
      illegal_q <= rej;
      if (acc) begin
        board_q     <= board_d;
        move_cnt_q  <= move_cnt_q + 1'b1;
        last_pos_q  <= acc_pos;
        last_mark_q <= acc_mark;
        win_q       <= 1'b0;
        dir_q       <= 2'd0;
        busy_q      <= 1'b1;
        state_q     <= CHK;
      end else if (state_q == CHK) begin
        dir_q <= dir_q + 2'd1;
        if (dir_q == 2'd3) begin
          busy_q <= 1'b0;
          if (win_d) begin
            who_q   <= last_mark_q;
            state_q <= DONE;
          end else if (move_cnt_q == CELLS_C) begin
            who_q   <= 2'b11;
            state_q <= DONE;
          end else begin
            turn_q  <= ~turn_q;
            state_q <= turn_q ? P_TURN : C_TURN;
          end
        end else begin
          win_q <= win_d;
        end
      end
    end
  end

  assign board     = board_q;
  assign who       = who_q;
  assign turn      = turn_q;
  assign busy      = busy_q;
  assign illegal   = illegal_q;
  assign move_cnt  = move_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_nxn_game_engine.sv
// Directed bench for nxn_game_engine: a 3x3/K=3 instance and a 5x5/K=4 instance.
module tb_nxn_game_engine;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  logic clr;

  // 3x3, K=3 instance
  logic        pp3, pc3;
  logic [3:0]  ppos3, cpos3;
  logic [17:0] board3;
  logic [1:0]  who3;
  logic        turn3, busy3, ill3;
  logic [3:0]  cnt3;
  logic [1:0]  st3;

  // 5x5, K=4 instance
  logic        pp5, pc5;
  logic [4:0]  ppos5, cpos5;
  logic [49:0] board5;
  logic [1:0]  who5;
  logic        turn5, busy5, ill5;
  logic [4:0]  cnt5;
  logic [1:0]  st5;

  nxn_game_engine #(.N(3), .K(3)) u_dut3 (
    .clk(clk), .rst(rst), .clr(clr), .pp(pp3), .pc(pc3),
    .player_position(ppos3), .computer_position(cpos3),
    .board(board3), .who(who3), .turn(turn3), .busy(busy3),
    .illegal(ill3), .move_cnt(cnt3), .dbg_state(st3)
  );

  nxn_game_engine #(.N(5), .K(4)) u_dut5 (
    .clk(clk), .rst(rst), .clr(clr), .pp(pp5), .pc(pc5),
    .player_position(ppos5), .computer_position(cpos5),
    .board(board5), .who(who5), .turn(turn5), .busy(busy5),
    .illegal(ill5), .move_cnt(cnt5), .dbg_state(st5)
  );

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  logic [17:0] m3;
  logic [49:0] m5;
  int n3, n5;
  int ic3 = 0;
  int ic5 = 0;

  always @(negedge clk) begin
    if (ill3 === 1'b1) ic3 = ic3 + 1;
    if (ill5 === 1'b1) ic5 = ic5 + 1;
  end

  task automatic sb_push(input logic [63:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [63:0] obs);
    logic [63:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL %s observed=%0h with no expected value queued", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, e);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    m3 = '0; n3 = 0; m5 = '0; n5 = 0;
    sb_push(64'(0)); check("clr_board3", 64'(board3));
    sb_push(64'(0)); check("clr_who3", 64'(who3));
  endtask

  // Accepted move on the 3x3 engine, strobe held for 5 cycles.
  task automatic mv3(input bit side, input int pos, input logic [1:0] ew);
    m3[2*pos +: 2] = side ? 2'b10 : 2'b01;
    n3++;
    @(negedge clk);
    if (side) begin pc3 = 1'b1; cpos3 = 4'(pos); end
    else      begin pp3 = 1'b1; ppos3 = 4'(pos); end
    @(negedge clk);
    sb_push(64'(m3)); check("mv3_board", 64'(board3));
    sb_push(64'(1));  check("mv3_busy_first", 64'(busy3));
    repeat (3) @(negedge clk);
    sb_push(64'(1));  check("mv3_busy_last", 64'(busy3));
    sb_push(64'(0));  check("mv3_who_early", 64'(who3));
    @(negedge clk);
    pp3 = 1'b0; pc3 = 1'b0;
    sb_push(64'(0));  check("mv3_busy_done", 64'(busy3));
    sb_push(64'(ew)); check("mv3_who", 64'(who3));
    sb_push(64'(n3)); check("mv3_cnt", 64'(cnt3));
    sb_push(64'((ew == 2'b00) ? !side : side)); check("mv3_turn", 64'(turn3));
  endtask

  // Accepted move on the 5x5 engine.
  task automatic mv5(input bit side, input int pos, input logic [1:0] ew);
    m5[2*pos +: 2] = side ? 2'b10 : 2'b01;
    n5++;
    @(negedge clk);
    if (side) begin pc5 = 1'b1; cpos5 = 5'(pos); end
    else      begin pp5 = 1'b1; ppos5 = 5'(pos); end
    repeat (5) @(negedge clk);
    pp5 = 1'b0; pc5 = 1'b0;
    sb_push(64'(m5)); check("mv5_board", board5);
    sb_push(64'(ew)); check("mv5_who", 64'(who5));
    sb_push(64'(n5)); check("mv5_cnt", 64'(cnt5));
  endtask

  // One-cycle strobe expected to be rejected by the 3x3 engine.
  task automatic rej3(input string tag, input bit side, input int pos, input bit exp_turn);
    int base;
    base = ic3;
    @(negedge clk);
    if (side) begin pc3 = 1'b1; cpos3 = 4'(pos); end
    else      begin pp3 = 1'b1; ppos3 = 4'(pos); end
    @(negedge clk);
    pp3 = 1'b0; pc3 = 1'b0;
    @(negedge clk);
    sb_push(64'(1));        check({tag, "_illegal_pulses"}, 64'(ic3 - base));
    sb_push(64'(m3));       check({tag, "_board"}, 64'(board3));
    sb_push(64'(exp_turn)); check({tag, "_turn"}, 64'(turn3));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int base;
    rst = 1'b0; clr = 1'b0;
    pp3 = 1'b0; pc3 = 1'b0; ppos3 = '0; cpos3 = '0;
    pp5 = 1'b0; pc5 = 1'b0; ppos5 = '0; cpos5 = '0;
    m3 = '0; m5 = '0; n3 = 0; n5 = 0;

    // reset state
    repeat (2) @(negedge clk);
    sb_push(64'(0)); check("rst_board3", 64'(board3));
    sb_push(64'(0)); check("rst_who3", 64'(who3));
    sb_push(64'(0)); check("rst_turn3", 64'(turn3));
    sb_push(64'(0)); check("rst_busy3", 64'(busy3));
    sb_push(64'(0)); check("rst_illegal3", 64'(ill3));
    sb_push(64'(0)); check("rst_cnt3", 64'(cnt3));
    sb_push(64'(0)); check("rst_board5", board5);
    rst = 1'b1;

    // computer wins on the top row
    mv3(1'b0, 4, 2'b00);
    mv3(1'b1, 0, 2'b00);
    mv3(1'b0, 8, 2'b00);
    mv3(1'b1, 1, 2'b00);
    mv3(1'b0, 6, 2'b00);
    mv3(1'b1, 2, 2'b10);
    sb_push(64'(0)); check("gameA_no_illegal", 64'(ic3));

    // player wins on the top row, then a move after game over is rejected
    do_clr();
    mv3(1'b0, 0, 2'b00);
    mv3(1'b1, 4, 2'b00);
    mv3(1'b0, 1, 2'b00);
    mv3(1'b1, 8, 2'b00);
    mv3(1'b0, 2, 2'b01);
    rej3("after_done", 1'b1, 5, 1'b0);
    sb_push(64'(2'b01)); check("after_done_who", 64'(who3));

    // full board, no line: draw
    do_clr();
    mv3(1'b0, 0, 2'b00);
    mv3(1'b1, 1, 2'b00);
    mv3(1'b0, 2, 2'b00);
    mv3(1'b1, 4, 2'b00);
    mv3(1'b0, 3, 2'b00);
    mv3(1'b1, 5, 2'b00);
    mv3(1'b0, 7, 2'b00);
    mv3(1'b1, 6, 2'b00);
    mv3(1'b0, 8, 2'b11);

    // rejects: occupied, out of range, off-turn, edge during busy
    do_clr();
    mv3(1'b0, 4, 2'b00);
    rej3("occupied", 1'b1, 4, 1'b1);
    rej3("out_of_range", 1'b1, 9, 1'b1);
    rej3("off_turn", 1'b0, 0, 1'b1);
    base = ic3;
    m3[2*1 +: 2] = 2'b10;
    n3++;
    @(negedge clk); pc3 = 1'b1; cpos3 = 4'd1;
    @(negedge clk); pc3 = 1'b0;
    @(negedge clk); pc3 = 1'b1; cpos3 = 4'd7;
    @(negedge clk); pc3 = 1'b0;
    repeat (3) @(negedge clk);
    sb_push(64'(1));  check("busy_edge_illegal_pulses", 64'(ic3 - base));
    sb_push(64'(m3)); check("busy_edge_board", 64'(board3));
    sb_push(64'(0));  check("busy_edge_turn", 64'(turn3));
    sb_push(64'(n3)); check("busy_edge_cnt", 64'(cnt3));

    // 5x5, K=4: anti-diagonal 3,7,11,15; 3-long runs do not win
    do_clr();
    mv5(1'b0, 3, 2'b00);
    mv5(1'b1, 0, 2'b00);
    mv5(1'b0, 7, 2'b00);
    mv5(1'b1, 1, 2'b00);
    mv5(1'b0, 11, 2'b00);
    mv5(1'b1, 2, 2'b00);
    mv5(1'b0, 15, 2'b01);
    sb_push(64'(0)); check("gameE_no_illegal", 64'(ic5));

    // asynchronous reset in the middle of a check
    do_clr();
    @(negedge clk); pp3 = 1'b1; ppos3 = 4'd4;
    @(negedge clk); pp3 = 1'b0;
    sb_push(64'(1)); check("pre_rst_busy", 64'(busy3));
    #2 rst = 1'b0;
    #1;
    sb_push(64'(0)); check("async_rst_board", 64'(board3));
    sb_push(64'(0)); check("async_rst_who", 64'(who3));
    sb_push(64'(0)); check("async_rst_turn", 64'(turn3));
    sb_push(64'(0)); check("async_rst_busy", 64'(busy3));
    sb_push(64'(0)); check("async_rst_cnt", 64'(cnt3));
    @(negedge clk); rst = 1'b1;
    m3 = '0; n3 = 0;

    // clr coincident with a pp edge
    mv3(1'b0, 0, 2'b00);
    base = ic3;
    @(negedge clk); clr = 1'b1; pp3 = 1'b1; ppos3 = 4'd5;
    @(negedge clk); clr = 1'b0; pp3 = 1'b0;
    m3 = '0; n3 = 0;
    sb_push(64'(0)); check("clr_pp_board", 64'(board3));
    sb_push(64'(0)); check("clr_pp_illegal", 64'(ill3));
    sb_push(64'(0)); check("clr_pp_cnt", 64'(cnt3));
    sb_push(64'(0)); check("clr_pp_turn", 64'(turn3));
    repeat (2) @(negedge clk);
    sb_push(64'(0)); check("clr_pp_no_pulse", 64'(ic3 - base));

    total++;
    assert (exp_q.size() == 0) else begin
      bad++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
